// File: rtl/fir_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fir_pkg
// Desc     : Shared defaults and helpers for the FIR output stream buffer.
// Revision : 1.0 - initial release
// ============================================================================
package fir_pkg;

    localparam int C_DATA_WIDTH = 32;
    localparam int C_LEN_WIDTH  = 32;
    localparam int C_DEPTH      = 8;

    // The extra MSB of each pointer tells a full FIFO from an empty one.
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/axis_fifo_core.sv
`default_nettype none
// ============================================================================
// Module   : axis_fifo_core
// Desc     : First-word-fall-through AXI-Stream FIFO storing {tlast, data}.
// Revision : 1.0 - initial release
// ============================================================================
module axis_fifo_core
    import fir_pkg::*;
#(
    parameter int pDATA_WIDTH = C_DATA_WIDTH,
    parameter int DEPTH       = C_DEPTH
)(
    input  logic                   axis_clk,
    input  logic                   axis_rst_n,
    input  logic                   s_tvalid,
    input  logic [pDATA_WIDTH-1:0] s_tdata,
    input  logic                   s_tlast,
    output logic                   s_tready,
    output logic                   m_tvalid,
    output logic [pDATA_WIDTH-1:0] m_tdata,
    output logic                   m_tlast,
    input  logic                   m_tready,
    output logic [$clog2(DEPTH):0] level,
    output logic                   push
);

    localparam int c_ptr_w   = ptr_width(DEPTH);
    localparam int c_addr_w  = c_ptr_w - 1;
    localparam int c_entry_w = pDATA_WIDTH + 1;

    logic [c_entry_w-1:0] r_mem [DEPTH];
    logic [c_ptr_w-1:0]   r_wr_ptr;
    logic [c_ptr_w-1:0]   r_rd_ptr;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_push;
    logic                 w_pop;
    logic [c_entry_w-1:0] w_head;

    // Status depends on the pointer registers only, so s_tready never sees m_tready.
    assign w_full  = (r_wr_ptr[c_ptr_w-1] != r_rd_ptr[c_ptr_w-1]) &&
                     (r_wr_ptr[c_addr_w-1:0] == r_rd_ptr[c_addr_w-1:0]);
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign level   = r_wr_ptr - r_rd_ptr;

    assign s_tready = !w_full;
    assign m_tvalid = !w_empty;
    assign w_push   = s_tvalid && !w_full;
    assign w_pop    = m_tready && !w_empty;
    assign push     = w_push;

    assign w_head  = r_mem[r_rd_ptr[c_addr_w-1:0]];
    assign m_tdata = w_head[pDATA_WIDTH-1:0];
    assign m_tlast = w_head[pDATA_WIDTH];

    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            end
        end
    end

    // Storage is cleared on reset so the output bus reads zero until the first write.
    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_push) begin
            r_mem[r_wr_ptr[c_addr_w-1:0]] <= {s_tlast, s_tdata};
        end
    end

endmodule
`default_nettype wire

// File: rtl/fir_out_fifo.sv
`default_nettype none
// ============================================================================
// Module   : fir_out_fifo
// Desc     : FIR result stream buffer with per-frame length checking.
// Revision : 1.0 - initial release
// ============================================================================
module fir_out_fifo
    import fir_pkg::*;
#(
    parameter int pDATA_WIDTH = C_DATA_WIDTH,
    parameter int DEPTH       = C_DEPTH,
    parameter int pLEN_WIDTH  = C_LEN_WIDTH
)(
    input  logic                   axis_clk,
    input  logic                   axis_rst_n,
    input  logic                   s_tvalid,
    input  logic [pDATA_WIDTH-1:0] s_tdata,
    input  logic                   s_tlast,
    output logic                   s_tready,
    output logic                   m_tvalid,
    output logic [pDATA_WIDTH-1:0] m_tdata,
    output logic                   m_tlast,
    input  logic                   m_tready,
    input  logic [pLEN_WIDTH-1:0]  data_length,
    input  logic                   clr_err,
    output logic [$clog2(DEPTH):0] level,
    output logic                   frame_done,
    output logic                   len_err
);

    localparam logic [pLEN_WIDTH-1:0] c_count_max = '1;

    logic                  w_push;
    logic [pLEN_WIDTH-1:0] r_count;
    logic [pLEN_WIDTH:0]   w_count_inc;
    logic [pLEN_WIDTH:0]   w_len_ext;
    logic                  w_len_set;
    logic                  r_frame_done;
    logic                  r_len_err;

    axis_fifo_core #(
        .pDATA_WIDTH (pDATA_WIDTH),
        .DEPTH       (DEPTH)
    ) u_core (
        .axis_clk   (axis_clk),
        .axis_rst_n (axis_rst_n),
        .s_tvalid   (s_tvalid),
        .s_tdata    (s_tdata),
        .s_tlast    (s_tlast),
        .s_tready   (s_tready),
        .m_tvalid   (m_tvalid),
        .m_tdata    (m_tdata),
        .m_tlast    (m_tlast),
        .m_tready   (m_tready),
        .level      (level),
        .push       (w_push)
    );

    // One extra bit keeps count+1 exact even when the counter is saturated.
    assign w_count_inc = {1'b0, r_count} + (pLEN_WIDTH+1)'(1);
    assign w_len_ext   = {1'b0, data_length};
    assign w_len_set   = w_push && (data_length != '0) &&
                         (s_tlast ? (w_count_inc != w_len_ext)
                                  : (w_count_inc == w_len_ext));

    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            r_count      <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_push && s_tlast;
            if (w_push) begin
                if (s_tlast) begin
                    r_count <= '0;
                end else if (r_count != c_count_max) begin
                    r_count <= w_count_inc[pLEN_WIDTH-1:0];
                end
            end
        end
    end

    // A new error in the same cycle as clr_err keeps the flag set.
    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            r_len_err <= 1'b0;
        end else if (w_len_set) begin
            r_len_err <= 1'b1;
        end else if (clr_err) begin
            r_len_err <= 1'b0;
        end
    end

    assign frame_done = r_frame_done;
    assign len_err    = r_len_err;

endmodule
`default_nettype wire

// File: doc/fir_out_fifo.md
Name: fir_out_fifo

Overview:
AXI-Stream output buffer that sits directly downstream of the FIR core. It consumes the FIR result stream (sm_tvalid/sm_tdata/sm_tlast/sm_tready) and re-presents it to the downstream consumer through a first-word-fall-through FIFO. The FIR therefore never stalls on short consumer back-pressure bursts. The block also counts samples per frame and flags any mismatch between tlast position and the programmed data length (same value as the FIR 0x10 register).

Parameters:
pDATA_WIDTH, 32, stream data width
DEPTH, 8, FIFO entries; power of two, >= 2
pLEN_WIDTH, 32, width of the data_length input and the sample counter

Ports:
axis_clk  in  1  clock
axis_rst_n  in  1  reset; asynchronous assert, active-low
s_tvalid  in  1  input beat valid (from FIR sm_tvalid)
s_tdata  in  pDATA_WIDTH  input sample
s_tlast  in  1  last sample of frame
s_tready  out  1  FIFO can accept (to FIR sm_tready)
m_tvalid  out  1  output beat valid
m_tdata  out  pDATA_WIDTH  output sample
m_tlast  out  1  tlast carried with the sample
m_tready  in  1  consumer ready
data_length  in  pLEN_WIDTH  expected samples per frame; 0 disables the check; stable during a frame
clr_err  in  1  synchronous one-cycle clear of len_err
level  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
frame_done  out  1  one-cycle pulse, cycle after tlast beat accepted
len_err  out  1  sticky length-mismatch flag

Behaviour:
- Reset (axis_rst_n low, asynchronous): rd/wr pointers=0, level=0, s_tready=1 after release, m_tvalid=0, m_tdata=0, m_tlast=0, sample counter=0, frame_done=0, len_err=0. Assertion mid-frame discards all contents and the partial count.
- Storage: DEPTH x (pDATA_WIDTH+1) register array holding {tlast,data}. Pointers are $clog2(DEPTH)+1 bits wide, and the MSB distinguishes full from empty.
- Write: a beat is accepted when s_tvalid && s_tready. s_tready = (level != DEPTH) and is driven from registers only, with no combinational path from m_tready.
- Read: m_tvalid = (level != 0). m_tdata and m_tlast are taken from the entry at the read pointer (FWFT). A beat pops when m_tvalid && m_tready.
- Latency: a sample accepted at edge N shows m_tvalid=1 during the cycle after edge N. No same-cycle pass-through.
- Simultaneous push and pop: both occur and level is unchanged. When full, push is blocked by s_tready=0 even if a pop happens the same cycle; s_tready rises the cycle after the pop. When empty, nothing pops.
- Pointers wrap modulo DEPTH. The data held under m_tdata stays stable while m_tvalid && !m_tready.
- Sample counter, input side: increments on each accepted beat.
- Accepted beat with s_tlast=1: counter returns to 0. frame_done pulses on the next cycle. If data_length!=0 and count+1 != data_length, len_err is set.
- Accepted beat with s_tlast=0 and count+1 == data_length (data_length!=0): len_err is set (missing tlast) and the counter keeps counting.
- Counter saturates at its maximum value with no wrap.
- len_err is sticky. It is cleared by clr_err, or by reset. If clr_err coincides with a new error, set wins.
- Upstream AXI-Stream rule applies: s_tdata/s_tlast must hold while s_tvalid && !s_tready. The block does not check this.

Decomposition:
- Shared package fir_pkg: pDATA_WIDTH, pLEN_WIDTH defaults; a localparam function for pointer width ($clog2(DEPTH)+1).
- One sub-module, axis_fifo_core: pointers, storage, level, and both handshakes.
- fir_out_fifo wraps axis_fifo_core and adds the frame counter, frame_done and len_err.

Test Plan:
- Reset, then 3 beats (10, -20, 30) with m_tready=1 -> m_tdata 10, -20, 30 in order; each appears 1 cycle after acceptance; level returns to 0.
- m_tready=0, push 9 beats with DEPTH=8 -> s_tready drops after the 8th accept and level=8. Raise m_tready for one cycle -> one pop, s_tready=1 the next cycle, 9th beat accepted, level stays 8.
- Continuous push with m_tready toggling every cycle for 600 samples -> output order is identical to input, no loss or duplicate, and no pointer-wrap corruption.
- data_length=600, frame of 600 beats with tlast on beat 599 -> frame_done single pulse, len_err=0, m_tlast=1 only on the 600th output beat.
- data_length=600, tlast on beat 10 -> len_err=1 after that beat. Pulse clr_err -> len_err=0. Then 600 beats without tlast -> len_err=1 at beat 600. With data_length=0 and the same stimulus -> len_err stays 0.
- Assert axis_rst_n mid-frame with level=5 -> m_tvalid=0 and level=0 immediately (asynchronously). After release, the first new frame counts from 0 and is checked correctly.
